data_mem_sequencer: RTL and testbench
=====================================

// Module: data_mem_sequencer
// PURPOSE
//  Sequences and arbitrates data-memory accesses for the pipeline. Takes the decoded memWrite/memToReg
//  intent of the MEM-stage instruction plus a secondary DMA requester, grants one at a time (round-robin),
//  drives a req/ack memory port, stalls the pipeline until its access completes, and times out dead accesses.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  TIMEOUT  15  max cycles memReq may wait for memAck before abort (>=1)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       reset, asynchronous, active-low
//  cpuMemRead   in   1       MEM-stage load (memToReg)
//  cpuMemWrite  in   1       MEM-stage store (memWrite)
//  cpuAddr      in   ADDR_W  CPU address
//  cpuWData     in   DATA_W  CPU store data
//  cpuRData     out  DATA_W  CPU load data, valid when cpuStall falls
//  cpuStall     out  1       freeze pipeline
//  cpuErr       out  1       1-cycle pulse: CPU access timed out
//  dmaReq       in   1       DMA request, held until dmaDone
//  dmaWe        in   1       DMA write(1)/read(0)
//  dmaAddr      in   ADDR_W  DMA address
//  dmaWData     in   DATA_W  DMA write data
//  dmaRData     out  DATA_W  DMA read data, valid with dmaDone
//  dmaDone      out  1       1-cycle pulse: DMA access finished
//  dmaErr       out  1       1-cycle pulse with dmaDone on timeout
//  memReq       out  1       memory request, registered
//  memWe        out  1       memory write enable, registered
//  memAddr      out  ADDR_W  registered
//  memWData     out  DATA_W  registered
//  memRData     in   DATA_W  memory read data, valid with memAck
//  memAck       in   1       memory completion, 1 cycle
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, all outputs 0, timeout counter 0, lastGrant=DMA (CPU wins first tie).
//  - FSM: IDLE, CPU_ACC, DMA_ACC, CPU_DONE, DMA_DONE.
//  - IDLE: cpuReq=cpuMemRead|cpuMemWrite. Only one requester -> grant it. Both -> grant the one not lastGrant.
//    On grant: latch addr/data/we into mem* regs, memReq<=1, lastGrant<=winner, go x_ACC. None -> stay.
//  - cpuMemWrite&cpuMemRead both 1: treated as write.
//  - x_ACC: mem* outputs held stable. memAck=1 -> memReq<=0, read data latched into cpuRData/dmaRData
//    (writes latch 0), go x_DONE. Counter counts memReq cycles without ack; at count==TIMEOUT with no
//    ack -> memReq<=0, rdata<=0, err flag set, go x_DONE. Ack on the same cycle as timeout wins (no error).
//  - CPU_DONE: cpuStall=0, cpuErr=flag, one cycle, then IDLE. DMA_DONE: dmaDone=1, dmaErr=flag, then IDLE.
//  - cpuStall (combinational) = cpuReq & (state!=CPU_DONE). Pipeline advances on the CPU_DONE edge.
//    Min CPU latency: request cycle + 1 memReq cycle (ack immediate) + done cycle = stall 2 cycles.
//  - memAck outside x_ACC ignored (late ack after timeout never corrupts data).
//  - cpuReq dropping mid-access (flush): access still completes; result discarded; no cpuErr.
//  - dmaReq sampled only in IDLE; DMA may re-request the cycle after dmaDone.
//  - Counter cleared on every grant; width ceil(log2(TIMEOUT+1)).
// TESTING
//  1 Reset mid-CPU_ACC (memReq=1) -> memReq,cpuStall,cpuErr,dmaDone all 0 immediately; IDLE after release.
//  2 CPU load 0x100, memAck 3rd memReq cycle with memRData=0xDEADBEEF -> memReq 3 cycles,
//    cpuStall 4 cycles then 0 with cpuRData=0xDEADBEEF.
//  3 cpuMemWrite & dmaReq both set after reset, repeat twice -> grants CPU,DMA,CPU,DMA; memWe/memAddr match owner.
//  4 TIMEOUT=15, CPU store, no memAck -> memReq high exactly 15 cycles, cpuErr 1-cycle pulse, cpuRData=0;
//    memAck one cycle later ignored.
//  5 DMA read, memAck with memRData=0x12345678 on cycle TIMEOUT -> dmaDone pulse, dmaErr=0, dmaRData=0x12345678.
//  6 cpuMemRead&cpuMemWrite both 1 -> memWe=1, memWData=cpuWData.

Source files
------------

// File: rtl/data_mem_sequencer.sv
// Data-memory sequencer: round-robin arbitration between the MEM-stage CPU access and a DMA requester,
// one registered req/ack memory access at a time, with pipeline stall and access timeout.
module data_mem_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuMemRead,
  input  logic              cpuMemWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuStall,
  output logic              cpuErr,
  input  logic              dmaReq,
  input  logic              dmaWe,
  input  logic [ADDR_W-1:0] dmaAddr,
  input  logic [DATA_W-1:0] dmaWData,
  output logic [DATA_W-1:0] dmaRData,
  output logic              dmaDone,
  output logic              dmaErr,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
  output logic [2:0]        dbgState
);
  // Memory handshake: memReq and the mem* fields stay stable from grant until the cycle memAck is
  // sampled high (or the timeout fires); memAck is a one-cycle completion and is ignored outside an access.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CPU_ACC, DMA_ACC, CPU_DONE, DMA_DONE} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, cntInc;
  logic             lastGrantDma;
  logic             errFlag;
  logic             flushed;
  logic             cpuReq;
  logic             grantCpu, grantDma, finish, expire;

  assign cpuReq   = cpuMemRead | cpuMemWrite;
  assign cntInc   = cnt + CNT_W'(1);
  assign dbgState = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    grantCpu  = 1'b0;
    grantDma  = 1'b0;
    finish    = 1'b0;
    expire    = 1'b0;
    cpuErr    = 1'b0;
    dmaDone   = 1'b0;
    dmaErr    = 1'b0;
    // Gated by rst so the pipeline is released the instant reset asserts.
    cpuStall  = rst & cpuReq & (state != CPU_DONE);
    case (state)
      IDLE: begin
        if (cpuReq && (!dmaReq || lastGrantDma)) begin
          grantCpu  = 1'b1;
          nextState = CPU_ACC;
        end else if (dmaReq) begin
          grantDma  = 1'b1;
          nextState = DMA_ACC;
        end
      end
      CPU_ACC, DMA_ACC: begin
        // An ack arriving on the timeout cycle still completes the access normally.
        if (memAck) begin
          finish    = 1'b1;
          nextState = (state == CPU_ACC) ? CPU_DONE : DMA_DONE;
        end else if (cntInc == CNT_W'(TIMEOUT)) begin
          expire    = 1'b1;
          nextState = (state == CPU_ACC) ? CPU_DONE : DMA_DONE;
        end
      end
      CPU_DONE: begin
        cpuErr    = errFlag & ~flushed;
        nextState = IDLE;
      end
      DMA_DONE: begin
        dmaDone   = 1'b1;
        dmaErr    = errFlag;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWData     <= '0;
      cpuRData     <= '0;
      dmaRData     <= '0;
      cnt          <= '0;
      errFlag      <= 1'b0;
      flushed      <= 1'b0;
      lastGrantDma <= 1'b1;
    end else begin
      if (grantCpu) begin
        memReq       <= 1'b1;
        memWe        <= cpuMemWrite;
        memAddr      <= cpuAddr;
        memWData     <= cpuWData;
        lastGrantDma <= 1'b0;
        cnt          <= '0;
        errFlag      <= 1'b0;
        flushed      <= 1'b0;
      end else if (grantDma) begin
        memReq       <= 1'b1;
        memWe        <= dmaWe;
        memAddr      <= dmaAddr;
        memWData     <= dmaWData;
        lastGrantDma <= 1'b1;
        cnt          <= '0;
        errFlag      <= 1'b0;
        flushed      <= 1'b0;
      end
      // A CPU request dropped mid-access is a pipeline flush: finish the access, suppress the error.
      if (state == CPU_ACC && !cpuReq) flushed <= 1'b1;
      if (finish) begin
        memReq <= 1'b0;
        if (state == CPU_ACC) cpuRData <= memWe ? '0 : memRData;
        else                  dmaRData <= memWe ? '0 : memRData;
      end else if (expire) begin
        memReq  <= 1'b0;
        errFlag <= 1'b1;
        if (state == CPU_ACC) cpuRData <= '0;
        else                  dmaRData <= '0;
      end else if (state == CPU_ACC || state == DMA_ACC) begin
        cnt <= cntInc;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_sequencer.sv
// Randomised bench for data_mem_sequencer: the bench plays the memory, predicts grant order from a
// round-robin model and predicts each access outcome from the ack delay it chose.
module tb_data_mem_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpuMemRead, cpuMemWrite;
  logic [AW-1:0] cpuAddr;
  logic [DW-1:0] cpuWData, cpuRData;
  logic          cpuStall, cpuErr;
  logic          dmaReq, dmaWe;
  logic [AW-1:0] dmaAddr;
  logic [DW-1:0] dmaWData, dmaRData;
  logic          dmaDone, dmaErr;
  logic          memReq, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWData, memRData;
  logic          memAck;
  logic [2:0]    dbgState;

  data_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpuMemRead(cpuMemRead), .cpuMemWrite(cpuMemWrite), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuRData(cpuRData), .cpuStall(cpuStall), .cpuErr(cpuErr),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWData(dmaWData),
    .dmaRData(dmaRData), .dmaDone(dmaDone), .dmaErr(dmaErr),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  int stallCnt;
  bit modelLastDma;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called in the IDLE cycle that precedes this owner's grant; returns in the IDLE cycle after its done.
  task automatic serve(input bit isCpu, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int d, input logic [DW-1:0] rdv,
                       input int flushAt, input bit chkStall);
    int n;
    int used;
    bit err;
    logic [DW-1:0] expRd;
    @(negedge clk); #1;
    check(isCpu ? "cpu_granted" : "dma_granted", memReq, 1);
    check("mem_we", memWe, we);
    check("mem_addr", memAddr, addr);
    check("mem_wdata", memWData, wdata);
    n = 0;
    while (memReq && n < TO + 5) begin
      n++;
      if (isCpu && cpuStall) stallCnt++;
      if (isCpu && n == flushAt) begin
        cpuMemRead  = 1'b0;
        cpuMemWrite = 1'b0;
      end
      memAck   = (n == d);
      memRData = (n == d) ? rdv : DW'($urandom);
      @(negedge clk); #1;
      memAck = 1'b0;
    end
    used  = (d < TO) ? d : TO;
    err   = (d > TO);
    expRd = (err || we) ? '0 : rdv;
    check("req_cycles", n, used);
    if (isCpu) begin
      check("cpu_stall_done", cpuStall, 0);
      check("cpu_err", cpuErr, err && flushAt == 0);
      check("cpu_rdata", cpuRData, expRd);
      if (chkStall) check("cpu_stall_cycles", stallCnt, used + 1);
      cpuMemRead  = 1'b0;
      cpuMemWrite = 1'b0;
    end else begin
      check("dma_done", dmaDone, 1);
      check("dma_err", dmaErr, err);
      check("dma_rdata", dmaRData, expRd);
      check("cpu_wait_stall", cpuStall, cpuMemRead | cpuMemWrite);
      dmaReq = 1'b0;
    end
    if (err) begin
      memAck   = 1'b1;
      memRData = ~rdv;
    end
    @(negedge clk); #1;
    memAck = 1'b0;
    if (isCpu) begin
      check("cpu_err_pulse", cpuErr, 0);
      check("cpu_rdata_hold", cpuRData, expRd);
    end else begin
      check("dma_done_pulse", dmaDone, 0);
      check("dma_rdata_hold", dmaRData, expRd);
    end
  endtask

  // cpuOp: 0 none, 1 load, 2 store, 3 load+store
  task automatic round(input int cpuOp, input bit dmaOn, input bit dmaW, input int dC, input int dD,
                       input logic [DW-1:0] rC, input logic [DW-1:0] rD, input int flushAt);
    logic [AW-1:0] ca = AW'($urandom);
    logic [AW-1:0] da = AW'($urandom);
    logic [DW-1:0] cw = DW'($urandom);
    logic [DW-1:0] dw = DW'($urandom);
    bit cpuOn = (cpuOp != 0);
    bit cpuW  = (cpuOp >= 2);
    bit cpuFirst;
    @(negedge clk);
    cpuMemRead  = (cpuOp == 1 || cpuOp == 3);
    cpuMemWrite = cpuW;
    cpuAddr     = ca;
    cpuWData    = cw;
    dmaReq      = dmaOn;
    dmaWe       = dmaW;
    dmaAddr     = da;
    dmaWData    = dw;
    #1;
    check("stall_on_request", cpuStall, cpuOn);
    stallCnt = cpuStall ? 1 : 0;
    cpuFirst = cpuOn && (!dmaOn || modelLastDma);
    if (cpuFirst) begin
      serve(1'b1, cpuW, ca, cw, dC, rC, flushAt, flushAt == 0);
      if (dmaOn) serve(1'b0, dmaW, da, dw, dD, rD, 0, 1'b0);
      modelLastDma = dmaOn;
    end else begin
      serve(1'b0, dmaW, da, dw, dD, rD, 0, 1'b0);
      if (cpuOn) serve(1'b1, cpuW, ca, cw, dC, rC, flushAt, 1'b0);
      modelLastDma = !cpuOn;
    end
  endtask

  initial begin
    rst = 1'b0;
    cpuMemRead = 1'b0; cpuMemWrite = 1'b0; cpuAddr = '0; cpuWData = '0;
    dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = '0; dmaWData = '0;
    memRData = '0; memAck = 1'b0;
    modelLastDma = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_memReq", memReq, 0);
    check("rst_state", dbgState, 0);
    check("rst_cpuRData", cpuRData, 0);
    check("rst_dmaDone", dmaDone, 0);
    @(negedge clk) rst = 1'b1;

    // reset while an access is in flight
    @(negedge clk);
    cpuMemRead = 1'b1;
    cpuAddr    = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    check("mid_acc_memReq", memReq, 1);
    rst = 1'b0;
    #1;
    check("async_rst_memReq", memReq, 0);
    check("async_rst_stall", cpuStall, 0);
    check("async_rst_cpuErr", cpuErr, 0);
    check("async_rst_dmaDone", dmaDone, 0);
    check("async_rst_state", dbgState, 0);
    cpuMemRead = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_idle", dbgState, 0);
    check("post_rst_memReq", memReq, 0);
    modelLastDma = 1'b1;

    // CPU store and DMA read contending twice: CPU, DMA, CPU, DMA
    repeat (2) round(2, 1'b1, 1'b0, $urandom_range(1, 4), $urandom_range(1, 4),
                     DW'($urandom), DW'($urandom), 0);
    // load acked on the 3rd memReq cycle
    round(1, 1'b0, 1'b0, 3, 0, 32'hDEADBEEF, 32'h0, 0);
    // store that never gets an ack, then a late ack
    round(2, 1'b0, 1'b0, TO + 2, 0, DW'($urandom), 32'h0, 0);
    // DMA read acked exactly on the timeout cycle
    round(0, 1'b1, 1'b0, 0, TO, 32'h0, 32'h12345678, 0);
    // load+store together is a store
    round(3, 1'b0, 1'b0, 2, 0, DW'($urandom), 32'h0, 0);
    // flushed load that times out reports no error
    round(1, 1'b0, 1'b0, TO + 2, 0, DW'($urandom), 32'h0, 3);

    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 3);
      bit dOn = 1'($urandom_range(0, 1));
      if (op == 0) dOn = 1'b1;
      round(op, dOn, 1'($urandom_range(0, 1)), $urandom_range(1, TO + 2), $urandom_range(1, TO + 2),
            DW'($urandom), DW'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
